// File: rtl/bitstream_byte_scheduler_if.sv
// Purpose: bundles the stage-4 burst inputs and the byte-stream output handshake of the scheduler.
// Latency: none, wiring only.
// Backpressure: out_ready (downstream) and out_stall (toward the pipeline) both travel through here.
interface bitstream_byte_scheduler_if #(
    parameter int SCH_BITSTREAM_WIDTH = 8
);
    logic [SCH_BITSTREAM_WIDTH-1:0] in_carry_bit_1;
    logic [SCH_BITSTREAM_WIDTH-1:0] in_carry_bit_2;
    logic [SCH_BITSTREAM_WIDTH-1:0] in_carry_bit_3;
    logic [SCH_BITSTREAM_WIDTH-1:0] in_carry_last_bit;
    logic [2:0]                     in_carry_flag_bitstream;
    logic                           in_flag_last;
    logic                           in_carry_error;
    logic [SCH_BITSTREAM_WIDTH-1:0] out_byte;
    logic                           out_valid;
    logic                           out_ready;
    logic                           out_byte_last;
    logic                           out_stall;
    logic                           out_frame_done;
    logic                           out_error;
    logic [31:0]                    out_byte_total;

    // Pipeline plus downstream sink side.
    modport master (
        output in_carry_bit_1, in_carry_bit_2, in_carry_bit_3, in_carry_last_bit,
        output in_carry_flag_bitstream, in_flag_last, in_carry_error, out_ready,
        input  out_byte, out_valid, out_byte_last, out_stall, out_frame_done,
        input  out_error, out_byte_total
    );

    // Scheduler side.
    modport slave (
        input  in_carry_bit_1, in_carry_bit_2, in_carry_bit_3, in_carry_last_bit,
        input  in_carry_flag_bitstream, in_flag_last, in_carry_error, out_ready,
        output out_byte, out_valid, out_byte_last, out_stall, out_frame_done,
        output out_error, out_byte_total
    );
endinterface

// File: rtl/bitstream_byte_scheduler.sv
// Purpose: buffers 0-4 byte bursts from the carry stage in a show-ahead FIFO, drains one byte per cycle, runs the frame flush.
// Latency: a byte written at edge N is on out_byte with out_valid in cycle N+1.
// Backpressure: holds the head byte while out_ready is low; registered out_stall when free < threshold or flushing. Optional byte counter: SCH_BYTE_STATS_EN.
module bitstream_byte_scheduler #(
    parameter int SCH_BITSTREAM_WIDTH = 8,
    parameter int SCH_FIFO_DEPTH      = 16,
    parameter int SCH_ADDR_WIDTH      = 4,
    parameter int SCH_STALL_THRESHOLD = 8
) (
    input  logic                          sch_clk,
    input  logic                          sch_reset,
    bitstream_byte_scheduler_if.slave     bus
);
    localparam int CW = SCH_ADDR_WIDTH + 1;
    localparam logic [CW-1:0] LP_DEPTH  = CW'(SCH_FIFO_DEPTH);
    localparam logic [CW-1:0] LP_THRESH = CW'(SCH_STALL_THRESHOLD);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [SCH_BITSTREAM_WIDTH:0]   r_mem [SCH_FIFO_DEPTH];
    logic [SCH_ADDR_WIDTH-1:0]      r_wr_ptr;
    logic [SCH_ADDR_WIDTH-1:0]      r_rd_ptr;
    logic [CW-1:0]                  r_count;
    logic                           r_stall;
    logic                           r_error;

    logic [2:0]                     w_n;
    logic [2:0]                     w_push_n;
    logic                           w_illegal;
    logic [CW-1:0]                  w_free;
    logic                           w_valid;
    logic                           w_pop;
    logic                           w_push;
    logic                           w_err_set;
    logic [SCH_BITSTREAM_WIDTH:0]   w_head;
    logic [SCH_BITSTREAM_WIDTH-1:0] w_bytes   [4];
    logic                           w_wr_en   [4];
    logic [SCH_ADDR_WIDTH-1:0]      w_wr_addr [4];
    logic [SCH_BITSTREAM_WIDTH:0]   w_wr_dat  [4];

    assign w_valid = (r_count != '0);
    assign w_head  = r_mem[r_rd_ptr];
    assign w_pop   = w_valid && bus.out_ready;
    assign w_free  = LP_DEPTH - r_count;

    // Decode the burst code into a byte count; codes above 4 carry no bytes.
    always_comb begin
        w_n       = 3'd0;
        w_illegal = 1'b0;
        case (bus.in_carry_flag_bitstream)
            3'd0:    w_n = 3'd0;
            3'd1:    w_n = 3'd1;
            3'd3:    w_n = 3'd2;
            3'd2:    w_n = 3'd3;
            3'd4:    w_n = 3'd4;
            default: w_illegal = 1'b1;
        endcase
    end

    // Next state, push acceptance and error sources. An overflowing burst is
    // treated as never delivered, so it does not move the FSM either.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_err_set   = bus.in_carry_error | w_illegal;
        case (r_state)
            S_IDLE, S_RUN: begin
                if (!w_illegal) begin
                    if (w_n != 3'd0) begin
                        if (CW'(w_n) > w_free) begin
                            w_err_set = 1'b1;
                        end else begin
                            w_push      = 1'b1;
                            w_state_nxt = bus.in_flag_last ? S_FLUSH : S_RUN;
                        end
                    end else if (bus.in_flag_last) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (bus.in_carry_flag_bitstream != 3'd0) w_err_set = 1'b1;
                if (w_pop && w_head[SCH_BITSTREAM_WIDTH]) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (bus.in_carry_flag_bitstream != 3'd0) w_err_set = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Lay the accepted burst out as up to four consecutive FIFO writes.
    always_comb begin
        w_bytes[0] = bus.in_carry_bit_1;
        w_bytes[1] = bus.in_carry_bit_2;
        w_bytes[2] = bus.in_carry_bit_3;
        w_bytes[3] = bus.in_carry_last_bit;
        w_push_n   = w_push ? w_n : 3'd0;
        for (int k = 0; k < 4; k++) begin
            w_wr_en[k]   = w_push && (3'(k) < w_n);
            w_wr_addr[k] = r_wr_ptr + SCH_ADDR_WIDTH'(k);
            w_wr_dat[k]  = {bus.in_flag_last && (3'(k) == w_n - 3'd1), w_bytes[k]};
        end
    end

    // FSM state register.
    always_ff @(posedge sch_clk or posedge sch_reset) begin
        if (sch_reset) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    // FIFO storage; contents past the read pointer are don't-care, so no reset.
    always_ff @(posedge sch_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (w_wr_en[k]) r_mem[w_wr_addr[k]] <= w_wr_dat[k];
        end
    end

    // Pointers, occupancy, registered stall and sticky error.
    always_ff @(posedge sch_clk or posedge sch_reset) begin
        if (sch_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_stall  <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + SCH_ADDR_WIDTH'(w_push_n);
            r_rd_ptr <= r_rd_ptr + SCH_ADDR_WIDTH'(w_pop);
            r_count  <= r_count + CW'(w_push_n) - CW'(w_pop);
            r_stall  <= (w_free < LP_THRESH) || (r_state == S_FLUSH);
            r_error  <= r_error | w_err_set;
        end
    end

    assign bus.out_valid      = w_valid;
    assign bus.out_byte       = w_valid ? w_head[SCH_BITSTREAM_WIDTH-1:0] : '0;
    assign bus.out_byte_last  = w_valid & w_head[SCH_BITSTREAM_WIDTH];
    assign bus.out_stall      = r_stall;
    assign bus.out_frame_done = (r_state == S_DONE);
    assign bus.out_error      = r_error;

`ifdef SCH_BYTE_STATS_EN
    logic [31:0] r_byte_total;

    // Popped-byte counter, free-running modulo 2^32.
    always_ff @(posedge sch_clk or posedge sch_reset) begin
        if (sch_reset)  r_byte_total <= 32'd0;
        else if (w_pop) r_byte_total <= r_byte_total + 32'd1;
    end

    assign bus.out_byte_total = r_byte_total;
`else
    assign bus.out_byte_total = 32'd0;
`endif
endmodule

// File: doc/bitstream_byte_scheduler.md
# bitstream_byte_scheduler

Output scheduler placed after the carry-propagation stage (stage 4) of the arithmetic-encoder pipeline. Each cycle it accepts a burst of 0–4 resolved bitstream bytes, buffers them in a byte FIFO, and drains them one byte per cycle through a valid/ready interface. It also raises a registered stall request toward the pipeline, detects overflow and illegal flag codes, and runs an end-of-frame flush sequence.

## Interface
- SCH_BITSTREAM_WIDTH, 8, byte width
- SCH_FIFO_DEPTH, 16, FIFO entries; power of two, ≥8
- SCH_ADDR_WIDTH, 4, log2(SCH_FIFO_DEPTH)
- SCH_STALL_THRESHOLD, 8, out_stall asserts when free entries < this value
- sch_clk  in  1  clock; all logic on the rising edge
- sch_reset  in  1  reset; asynchronous, active-high
- in_carry_bit_1/2/3  in  8 each  resolved bytes from stage 4, in stream order
- in_carry_last_bit  in  8  fourth byte; valid only with flag 4
- in_carry_flag_bitstream  in  3  burst code: 0 = none, 1 = bit_1, 3 = bit_1,2, 2 = bit_1,2,3, 4 = bit_1,2,3,last
- in_flag_last  in  1  the current burst ends the frame
- in_carry_error  in  1  error from stage 4; latched into out_error
- out_byte  out  8  head-of-FIFO byte
- out_valid  out  1  out_byte is valid
- out_ready  in  1  downstream accepts the byte
- out_byte_last  out  1  out_byte is the final byte of the frame
- out_stall  out  1  registered back-pressure request to the pipeline
- out_frame_done  out  1  one-cycle pulse once the frame has fully drained
- out_error  out  1  sticky error flag
- out_byte_total  out  32  count of popped bytes (see Configuration)

## Operation
- **Burst code to byte count:** 0→0, 1→1, 3→2, 2→3, 4→4. Codes 5–7 are illegal: no push, and out_error is set.
- **Push order:** bytes enter the FIFO in the order bit_1, bit_2, bit_3, last. Each entry stores 9 bits: {last_tag, byte}.
- **Frame tag:** when in_flag_last=1, last_tag=1 goes only on the final byte of that burst.
- **Pop:** a pop occurs when out_valid && out_ready. The FIFO is show-ahead; out_byte and out_byte_last come combinationally from the head entry.
- **Overflow:** if the burst size exceeds the free entries, computed before that cycle's pop, the whole burst is dropped and out_error is set. The FIFO is never partially written.
- **Simultaneous push and pop:** the count updates by push_n − pop (range −1…+4).
- **Pointer wrap:** pointers are SCH_ADDR_WIDTH bits and wrap modulo depth. The count is SCH_ADDR_WIDTH+1 bits.
- **Error latching:** out_error is set by overflow, an illegal code, in_carry_error, or any push while in FLUSH. It clears only on reset.
- **FSM states:** IDLE, RUN, FLUSH, DONE.
  - IDLE→RUN on the first nonzero legal burst. That burst is pushed.
  - RUN→FLUSH on a legal nonzero burst with in_flag_last=1. That burst is pushed.
  - A burst with code 0 and in_flag_last=1 pushes nothing, goes to FLUSH, and sets out_error.
  - In FLUSH, input bursts are ignored (not pushed) and set out_error. The FSM stays in FLUSH until the byte with last_tag=1 pops.
  - FLUSH→DONE on that pop. In DONE, out_frame_done=1 for exactly one cycle, then →IDLE.
  - In DONE, inputs are ignored. A nonzero burst there sets out_error.
- **Stall:** out_stall_next = (free < SCH_STALL_THRESHOLD) || state==FLUSH, registered.

## Timing
- **Reset values:** out_valid=0, out_byte=0, out_byte_last=0, out_stall=0, out_frame_done=0, out_error=0, out_byte_total=0. Pointers and count are 0 and the state is IDLE.
- **Latency:** a byte pushed at edge N appears on out_byte with out_valid=1 during cycle N+1. Minimum input-to-output latency is 1 cycle.
- **Drain rate:** at most 1 byte per cycle. A 4-byte burst into an empty FIFO with out_ready=1 drains over cycles N+1…N+4.
- **Stall timing:** out_stall reflects occupancy one cycle late. SCH_STALL_THRESHOLD ≥ 8 gives one cycle of slack for worst-case 4-byte bursts.
- **Handshake rules:** out_byte must hold while out_valid && !out_ready. out_valid never drops without a pop.
- **Reset mid-frame:** reset discards all buffered bytes immediately and asynchronously. No frame_done is generated.

## Configuration
- **SCH_BYTE_STATS_EN defined:** out_byte_total increments on each pop, wraps at 2^32, and is cleared by reset.
- **SCH_BYTE_STATS_EN undefined:** the counter logic is removed and out_byte_total is tied to 0.

## Test plan
- **Order and latency:** after reset, out_ready=1; push code 4 with bytes 0x11,0x22,0x33,0x44. Required: out_byte = 0x11, 0x22, 0x33, 0x44 in cycles N+1…N+4, with out_valid high exactly 4 cycles.
- **Back-pressure and stall:** out_ready=0; push code 2 three times (9 bytes). Required: out_stall=1 the cycle after count reaches 9 (free 7 < 8). out_byte holds 0x first byte throughout. out_error=0.
- **Overflow:** out_ready=0; fill to 14 entries, then push code 4. Required: the count stays 14, out_error=1, and the FIFO contents are unchanged when later drained.
- **Frame flush:** push code 3 (0xA0,0xA1) with in_flag_last=1. Required: out_byte_last=1 only on 0xA1. out_frame_done pulses 1 cycle after 0xA1 pops, then the state returns to IDLE. A code-1 push during FLUSH sets out_error and is not output.
- **Wrap and concurrency:** stream random legal bursts for 1000 cycles with out_ready toggling randomly while keeping free ≥ 4. Required: the output matches a reference queue byte-for-byte across pointer wrap. With SCH_BYTE_STATS_EN, out_byte_total equals the pop count.
- **Async reset mid-frame:** assert sch_reset mid-frame with 5 bytes buffered. Required: out_valid=0 without waiting for a clock edge, and all outputs hold their reset values.
